// File: rtl/writeback_stage_if.sv
// Memory-to-writeback stage bundle: retiring-instruction fields in,
// register-file write port and retirement status out.
interface writeback_stage_if;
  logic        in_valid;
  logic        flush;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_result_src;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result;
  logic [31:0] in_load_word;
  logic [31:0] in_pc_plus4;
  logic [31:0] in_imm;
  logic        enable_reg_write;
  logic [4:0]  addr_write;
  logic [31:0] write_data;
  logic        load_fault;
  logic [63:0] instret;

  modport master (
    output in_valid, flush, in_reg_write, in_rd, in_result_src, in_funct3,
           in_alu_result, in_load_word, in_pc_plus4, in_imm,
    input  enable_reg_write, addr_write, write_data, load_fault, instret
  );

  modport slave (
    input  in_valid, flush, in_reg_write, in_rd, in_result_src, in_funct3,
           in_alu_result, in_load_word, in_pc_plus4, in_imm,
    output enable_reg_write, addr_write, write_data, load_fault, instret
  );
endinterface

// File: rtl/writeback_stage.sv
// RV32 writeback stage: selects the result, extracts/extends load data, flags
// misaligned or illegal loads and counts retired instructions.
module writeback_stage (
  input  logic             clk,
  input  logic             reset,
  writeback_stage_if.slave wb
);
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;
  localparam logic [1:0] SRC_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic signed [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    ext_byte = {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic signed [31:0] ext_half(input logic [15:0] h, input logic sgn);
    ext_half = {{16{sgn & h[15]}}, h};
  endfunction

  logic [1:0]         off;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic signed [31:0] ld_data;
  logic signed [31:0] result;
  logic               ld_bad;
  logic               fault;
  logic               capture;

  always_comb begin
    off = wb.in_alu_result[1:0];
    case (off)
      2'd0:    ld_byte = wb.in_load_word[7:0];
      2'd1:    ld_byte = wb.in_load_word[15:8];
      2'd2:    ld_byte = wb.in_load_word[23:16];
      default: ld_byte = wb.in_load_word[31:24];
    endcase
    ld_half = off[1] ? wb.in_load_word[31:16] : wb.in_load_word[15:0];

    ld_bad  = 1'b0;
    ld_data = wb.in_load_word;
    case (wb.in_funct3)
      F3_LB:   ld_data = ext_byte(ld_byte, 1'b1);
      F3_LBU:  ld_data = ext_byte(ld_byte, 1'b0);
      F3_LH:   begin ld_data = ext_half(ld_half, 1'b1); ld_bad = off[0]; end
      F3_LHU:  begin ld_data = ext_half(ld_half, 1'b0); ld_bad = off[0]; end
      F3_LW:   ld_bad = (off != 2'b00);
      default: ld_bad = 1'b1;
    endcase

    case (wb.in_result_src)
      SRC_LOAD: result = ld_data;
      SRC_PC4:  result = wb.in_pc_plus4;
      SRC_IMM:  result = wb.in_imm;
      default:  result = wb.in_alu_result;
    endcase

    // Load-decode faults only matter when the load path is actually selected.
    fault   = (wb.in_result_src == SRC_LOAD) && ld_bad;
    capture = wb.in_valid && !wb.flush;
  end

  // ---- stage p1: registered writeback ----
  logic               vld_p1;
  logic               wr_req_p1;
  logic               fault_p1;
  logic [4:0]         rd_p1;
  logic signed [31:0] data_p1;
  logic [63:0]        instret_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      wr_req_p1   <= 1'b0;
      fault_p1    <= 1'b0;
      rd_p1       <= 5'd0;
      data_p1     <= '0;
      instret_cnt <= 64'd0;
    end else begin
      vld_p1 <= capture;
      if (capture) begin
        wr_req_p1 <= wb.in_reg_write && (wb.in_rd != 5'd0) && !fault;
        fault_p1  <= fault;
        rd_p1     <= wb.in_rd;
        data_p1   <= result;
        if (!fault)
          instret_cnt <= instret_cnt + 64'd1;
      end
    end
  end

  // Write/fault flags are qualified by the bubble bit so they last one cycle.
  assign wb.enable_reg_write = vld_p1 & wr_req_p1;
  assign wb.load_fault       = vld_p1 & fault_p1;
  assign wb.addr_write       = rd_p1;
  assign wb.write_data       = data_p1;
  assign wb.instret          = instret_cnt;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: reference model compared every cycle,
// plus literal checks on the hand-worked cases.
module tb_writeback_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  writeback_stage_if vi ();

  writeback_stage dut (
    .clk   (clk),
    .reset (reset),
    .wb    (vi)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the register-file port must show after each edge.
  logic        m_en = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_wd = 32'd0;
  logic        m_wd_known = 1'b1;
  logic        m_fault = 1'b0;
  logic [63:0] m_cnt = 64'd0;
  int          m_off;
  int          m_unit;
  logic [31:0] m_val;
  logic        m_bad;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_en = 1'b0; m_rd = 5'd0; m_wd = 32'd0; m_wd_known = 1'b1;
      m_fault = 1'b0; m_cnt = 64'd0;
    end else if (vi.in_valid && !vi.flush) begin
      m_off = int'(vi.in_alu_result % 4);
      m_bad = 1'b0;
      m_val = 32'd0;
      if (vi.in_result_src == 2'd0) m_val = vi.in_alu_result;
      else if (vi.in_result_src == 2'd2) m_val = vi.in_pc_plus4;
      else if (vi.in_result_src == 2'd3) m_val = vi.in_imm;
      else begin
        m_unit = (vi.in_funct3 % 4 == 0) ? 1 : (vi.in_funct3 % 4 == 1) ? 2 : 4;
        if (vi.in_funct3 == 3'd3 || vi.in_funct3 >= 3'd6 || (vi.in_funct3 == 3'd2 && m_off != 0))
          m_bad = 1'b1;
        else if (m_off % m_unit != 0 && m_unit == 2)
          m_bad = 1'b1;
        else if (m_unit == 4)
          m_val = vi.in_load_word;
        else begin
          if (m_unit == 2) m_off = (m_off / 2) * 2;
          m_val = (vi.in_load_word >> (8 * m_off)) % (m_unit == 1 ? 256 : 65536);
          if (vi.in_funct3 < 3'd4 && m_val >= (m_unit == 1 ? 128 : 32768))
            m_val = m_val - (m_unit == 1 ? 32'd256 : 32'd65536);
        end
      end
      m_rd = vi.in_rd;
      m_wd = m_val;
      m_wd_known = !m_bad;
      m_fault = m_bad;
      m_en = vi.in_reg_write && vi.in_rd != 0 && !m_bad;
      if (!m_bad) m_cnt = m_cnt + 1;
    end else begin
      m_en = 1'b0;
      m_fault = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("cmp_en", 64'(vi.enable_reg_write), 64'(m_en));
    chk("cmp_fault", 64'(vi.load_fault), 64'(m_fault));
    chk("cmp_addr", 64'(vi.addr_write), 64'(m_rd));
    chk("cmp_instret", vi.instret, m_cnt);
    if (m_wd_known) chk("cmp_wdata", 64'(vi.write_data), 64'(m_wd));
  end

  task automatic set_in(input logic v, input logic f, input logic rw, input logic [4:0] rd,
                        input logic [1:0] src, input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] lw, input logic [31:0] pc, input logic [31:0] imm);
    vi.in_valid = v; vi.flush = f; vi.in_reg_write = rw; vi.in_rd = rd;
    vi.in_result_src = src; vi.in_funct3 = f3; vi.in_alu_result = alu;
    vi.in_load_word = lw; vi.in_pc_plus4 = pc; vi.in_imm = imm;
  endtask

  task automatic issue(input logic v, input logic f, input logic rw, input logic [4:0] rd,
                       input logic [1:0] src, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] lw, input logic [31:0] pc, input logic [31:0] imm);
    @(negedge clk);
    set_in(v, f, rw, rd, src, f3, alu, lw, pc, imm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    vi.in_valid = 1'b0;
    vi.flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    // LB staged while still in reset: captured on the very first free edge.
    set_in(1, 0, 1, 5'd5, 2'b01, 3'b000, 32'h0000_1003, 32'h80FF_1234, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_en", 64'(vi.enable_reg_write), 64'd0);
    chk("rst_addr", 64'(vi.addr_write), 64'd0);
    chk("rst_wdata", 64'(vi.write_data), 64'd0);
    chk("rst_fault", 64'(vi.load_fault), 64'd0);
    chk("rst_instret", vi.instret, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("lb_en", 64'(vi.enable_reg_write), 64'd1);
    chk("lb_addr", 64'(vi.addr_write), 64'd5);
    chk("lb_wdata", 64'(vi.write_data), 64'hFFFF_FF80);
    chk("lb_instret", vi.instret, 64'd1);

    issue(1, 0, 1, 5'd6, 2'b01, 3'b101, 32'h0000_2002, 32'hBEEF_0000, 32'd0, 32'd0);
    chk("lhu_wdata", 64'(vi.write_data), 64'h0000_BEEF);
    chk("lhu_instret", vi.instret, 64'd2);

    issue(1, 0, 1, 5'd7, 2'b01, 3'b010, 32'h0000_3001, 32'h1111_2222, 32'd0, 32'd0);
    chk("lw_mis_en", 64'(vi.enable_reg_write), 64'd0);
    chk("lw_mis_fault", 64'(vi.load_fault), 64'd1);
    chk("lw_mis_instret", vi.instret, 64'd2);

    issue(1, 0, 1, 5'd1, 2'b10, 3'b000, 32'h0000_0003, 32'd0, 32'h0000_0104, 32'd0);
    chk("jal_wdata", 64'(vi.write_data), 64'h0000_0104);
    chk("jal_en", 64'(vi.enable_reg_write), 64'd1);
    chk("fault_one_cycle", 64'(vi.load_fault), 64'd0);

    issue(1, 0, 1, 5'd0, 2'b10, 3'b000, 32'd0, 32'd0, 32'h0000_0104, 32'd0);
    chk("rd0_en", 64'(vi.enable_reg_write), 64'd0);
    chk("rd0_instret", vi.instret, 64'd4);

    issue(1, 1, 1, 5'd7, 2'b00, 3'b000, 32'h0000_0055, 32'd0, 32'd0, 32'd0);
    chk("flush_en", 64'(vi.enable_reg_write), 64'd0);
    chk("flush_fault", 64'(vi.load_fault), 64'd0);
    chk("flush_instret", vi.instret, 64'd4);
    chk("flush_addr_hold", 64'(vi.addr_write), 64'd0);

    issue(1, 0, 1, 5'd10, 2'b01, 3'b000, 32'h0000_0000, 32'h1234_567F, 32'd0, 32'd0);
    chk("lb_pos_wdata", 64'(vi.write_data), 64'h0000_007F);
    issue(1, 0, 1, 5'd11, 2'b01, 3'b001, 32'h0000_0002, 32'h8001_0000, 32'd0, 32'd0);
    chk("lh_neg_wdata", 64'(vi.write_data), 64'hFFFF_8001);
    issue(1, 0, 1, 5'd12, 2'b01, 3'b100, 32'h0000_0001, 32'h0000_9A00, 32'd0, 32'd0);
    chk("lbu_wdata", 64'(vi.write_data), 64'h0000_009A);
    issue(1, 0, 1, 5'd13, 2'b11, 3'b011, 32'h0000_0001, 32'd0, 32'd0, 32'hABCD_E000);
    chk("imm_wdata", 64'(vi.write_data), 64'hABCD_E000);
    chk("imm_nofault", 64'(vi.load_fault), 64'd0);
    chk("imm_instret", vi.instret, 64'd8);
    issue(1, 0, 1, 5'd13, 2'b01, 3'b011, 32'h0000_0000, 32'd0, 32'd0, 32'd0);
    chk("illegal_fault", 64'(vi.load_fault), 64'd1);
    issue(1, 0, 1, 5'd14, 2'b01, 3'b001, 32'h0000_0003, 32'hFFFF_FFFF, 32'd0, 32'd0);
    chk("lh_mis_fault", 64'(vi.load_fault), 64'd1);
    chk("lh_mis_en", 64'(vi.enable_reg_write), 64'd0);
    issue(1, 0, 1, 5'd14, 2'b01, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 32'd0);
    chk("lw_wdata", 64'(vi.write_data), 64'hDEAD_BEEF);
    chk("lw_instret", vi.instret, 64'd9);

    // Jump the retirement counter to its last value, then retire once more.
    idle();
    #2;
    force dut.instret_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_cnt;
    issue(1, 0, 0, 5'd2, 2'b00, 3'b000, 32'h0000_0077, 32'd0, 32'd0, 32'd0);
    chk("wrap_instret", vi.instret, 64'd0);
    chk("wrap_en", 64'(vi.enable_reg_write), 64'd0);

    issue(1, 0, 1, 5'd9, 2'b00, 3'b000, 32'h1234_5678, 32'd0, 32'd0, 32'd0);
    chk("pre_rst_en", 64'(vi.enable_reg_write), 64'd1);
    reset = 1'b1;
    vi.in_valid = 1'b0;
    #1;
    chk("async_rst_en", 64'(vi.enable_reg_write), 64'd0);
    chk("async_rst_addr", 64'(vi.addr_write), 64'd0);
    chk("async_rst_wdata", 64'(vi.write_data), 64'd0);
    chk("async_rst_instret", vi.instret, 64'd0);
    @(negedge clk);
    chk("rst_no_write", 64'(vi.enable_reg_write), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    issue(1, 0, 1, 5'd3, 2'b00, 3'b000, 32'h0000_0055, 32'd0, 32'd0, 32'd0);
    chk("post_rst_wdata", 64'(vi.write_data), 64'h0000_0055);
    chk("post_rst_instret", vi.instret, 64'd1);
    idle();
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
